// File: rtl/sram_1r1w_pipe.sv
// Behavioural 1R1W SRAM with masked writes, pipelined reads,
// defined read-during-write behaviour and an optional zeroing sweep.
module sram_1r1w_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 1024,
    parameter int ADDR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int MASK_GRAN     = 8,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    output logic                            init_busy,
    input  logic                            W0_en,
    input  logic [ADDR_WIDTH-1:0]           W0_addr,
    input  logic [DATA_WIDTH-1:0]           W0_data,
    input  logic [DATA_WIDTH/MASK_GRAN-1:0] W0_mask,
    input  logic                            R0_en,
    input  logic [ADDR_WIDTH-1:0]           R0_addr,
    output logic [DATA_WIDTH-1:0]           R0_data,
    output logic                            R0_valid
);

    localparam int MASK_WIDTH = DATA_WIDTH / MASK_GRAN;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  rd_in;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [READ_LATENCY-1:0] pv;
    logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

    assign init_busy = (INIT_ON_RESET != 0) && (state != ST_IDLE);

    assign acc   = !reset && (state == ST_IDLE);
    assign wr_ok = acc && W0_en && ({1'b0, W0_addr} < DEPTH_W);
    assign rd_ok = acc && R0_en;
    assign rd_in = {1'b0, R0_addr} < DEPTH_W;

    // Init sequencer: hold in RESET, sweep every word to zero, then idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_RESET: begin
                    state <= (INIT_ON_RESET != 0) ? ST_SWEEP : ST_IDLE;
                end
                ST_SWEEP: begin
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                    end
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read word sampled in the accept cycle, with optional per-lane bypass.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[R0_addr];
        end
        if ((RDW_MODE != 0) && wr_ok && (W0_addr == R0_addr)) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (W0_mask[i]) begin
                    rd_word[i*MASK_GRAN +: MASK_GRAN] =
                        W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Array update: sweep zeroing or masked lane writes.
    always_ff @(posedge clock) begin
        if (!reset && (state == ST_SWEEP)) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (W0_mask[i]) begin
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <=
                        W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Read pipeline; data stages only move with a valid so output holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            pv <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= rd_ok;
            if (rd_ok) begin
                pd[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign R0_valid = pv[READ_LATENCY-1];
    assign R0_data  = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1r1w_pipe.sv
// Bench for sram_1r1w_pipe: two geometries driven in lockstep
// against a behavioural model with per-instance result queues.
module tb_sram_1r1w_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        W0_en;
    logic [3:0]  W0_addr;
    logic [31:0] W0_data;
    logic [3:0]  W0_mask;
    logic        R0_en;
    logic [3:0]  R0_addr;

    logic        busy_a, valid_a;
    logic [31:0] data_a;
    logic        busy_b, valid_b;
    logic [31:0] data_b;

    always #5 clock = ~clock;

    // A: DEPTH 12, latency 3, new-data RDW
    sram_1r1w_pipe #(
        .DATA_WIDTH(32), .DEPTH(12), .MASK_GRAN(8),
        .READ_LATENCY(3), .RDW_MODE(1), .INIT_ON_RESET(1)
    ) dut_a (
        .clock(clock), .reset(reset), .init_busy(busy_a),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W0_mask(W0_mask), .R0_en(R0_en), .R0_addr(R0_addr),
        .R0_data(data_a), .R0_valid(valid_a)
    );

    // B: DEPTH 16, latency 1, old-data RDW
    sram_1r1w_pipe #(
        .DATA_WIDTH(32), .DEPTH(16), .MASK_GRAN(8),
        .READ_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)
    ) dut_b (
        .clock(clock), .reset(reset), .init_busy(busy_b),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W0_mask(W0_mask), .R0_en(R0_en), .R0_addr(R0_addr),
        .R0_data(data_b), .R0_valid(valid_b)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mm   [2][16];
    int          phase[2];
    int          cnt  [2];
    logic [31:0] last [2];
    int          cyc        = 0;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of one edge for instance k, from the inputs of this cycle.
    task automatic model_pre(input int k);
        int          depth, lat;
        bit          rdw;
        logic [31:0] w;
        exp_t        e;
        depth = (k == 0) ? 12 : 16;
        lat   = (k == 0) ? 3 : 1;
        rdw   = (k == 0);
        if (reset) begin
            phase[k] = 0;
            cnt[k]   = 0;
            last[k]  = 32'h0;
            if (k == 0) qa.delete();
            else        qb.delete();
        end else if (phase[k] == 0) begin
            phase[k] = 1;
        end else if (phase[k] == 1) begin
            mm[k][cnt[k]] = 32'h0;
            if (cnt[k] == depth - 1) phase[k] = 2;
            cnt[k]++;
        end else begin
            if (R0_en) begin
                w = (int'(R0_addr) < depth) ? mm[k][R0_addr] : 32'h0;
                if (rdw && W0_en && W0_addr == R0_addr &&
                    int'(W0_addr) < depth) begin
                    for (int l = 0; l < 4; l++)
                        if (W0_mask[l]) w[l*8 +: 8] = W0_data[l*8 +: 8];
                end
                e.due  = cyc + 1 + lat - 1;
                e.data = w;
                if (k == 0) qa.push_back(e);
                else        qb.push_back(e);
            end
            if (W0_en && int'(W0_addr) < depth) begin
                for (int l = 0; l < 4; l++)
                    if (W0_mask[l])
                        mm[k][W0_addr][l*8 +: 8] = W0_data[l*8 +: 8];
            end
        end
    endtask

    // Compare instance k outputs after the edge against the model.
    task automatic model_post(input int k, input logic busy,
                              input logic v, input logic [31:0] d);
        logic ev;
        ev = 1'b0;
        if (k == 0) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                ev = 1'b1;
                last[0] = qa[0].data;
                void'(qa.pop_front());
            end
        end else begin
            if (qb.size() > 0 && qb[0].due == cyc) begin
                ev = 1'b1;
                last[1] = qb[0].data;
                void'(qb.pop_front());
            end
        end
        check($sformatf("busy%0d@%0d", k, cyc), {31'h0, busy},
              {31'h0, phase[k] != 2});
        check($sformatf("valid%0d@%0d", k, cyc), {31'h0, v}, {31'h0, ev});
        check($sformatf("data%0d@%0d", k, cyc), d, last[k]);
    endtask

    task automatic step();
        model_pre(0);
        model_pre(1);
        @(posedge clock);
        cyc++;
        #1;
        model_post(0, busy_a, valid_a, data_a);
        model_post(1, busy_b, valid_b, data_b);
    endtask

    task automatic drive(input logic we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input logic re, input logic [3:0] ra);
        W0_en   = we;
        W0_addr = wa;
        W0_data = wd;
        W0_mask = wm;
        R0_en   = re;
        R0_addr = ra;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    // Release reset and count busy cycles; noise requests must be ignored.
    task automatic sweep(input bit noise);
        int na, nb;
        na = 0;
        nb = 0;
        reset = 1'b0;
        for (int i = 0; i < 40 && (i == 0 || busy_a || busy_b); i++) begin
            if (noise && i < 8)
                drive(1, 4'(i), 32'hFFFF_FFFF, 4'hF, 1, 4'(i));
            else
                drive(0, 0, 0, 0, 0, 0);
            na += int'(busy_a);
            nb += int'(busy_b);
        end
        check("busy_cycles_a", 32'(na), 32'd12);
        check("busy_cycles_b", 32'(nb), 32'd16);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, 4'(i));
        idle(4);
    endtask

    initial begin
        reset = 1'b1;
        W0_en = 0; W0_addr = 0; W0_data = 0; W0_mask = 0;
        R0_en = 0; R0_addr = 0;
        phase[0] = 0; phase[1] = 0;
        cnt[0] = 0; cnt[1] = 0;
        last[0] = 0; last[1] = 0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) mm[k][a] = 32'h0;

        idle(3);
        sweep(1'b1);
        read_all();

        drive(1, 5, 32'hDEAD_BEEF, 4'b1111, 0, 0);
        drive(1, 5, 32'h1122_3344, 4'b0101, 0, 0);
        drive(0, 0, 0, 0, 1, 5);
        idle(4);

        drive(1, 7, 32'hAAAA_AAAA, 4'b1111, 0, 0);
        drive(1, 7, 32'h5555_5555, 4'b0011, 1, 7);
        drive(0, 0, 0, 0, 1, 7);
        idle(4);

        drive(1, 11, 32'h0BAD_F00D, 4'b1111, 0, 0);
        drive(1, 13, 32'h1234_5678, 4'b1111, 0, 0);
        drive(0, 0, 0, 0, 1, 13);
        idle(3);
        drive(0, 0, 0, 0, 1, 11);
        idle(5);

        for (int i = 0; i < 40; i++)
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        idle(4);
        read_all();

        drive(0, 0, 0, 0, 1, 5);
        drive(0, 0, 0, 0, 1, 7);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(7);
        reset = 1'b1;
        idle(2);
        sweep(1'b0);
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
